// File: rtl/boot_rom_loader_if.sv
// boot_rom_loader_if: ROM-read / RAM-write bus bundle for the boot loader.
// Ports: slave = loader side (drives ROM enable/address, RAM request/write, status);
//        master = environment side (drives start, ROM read data, RAM grant).
interface boot_rom_loader_if #(
    parameter int ROM_ADDR_WIDTH = 12,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 32
);
    logic                      start_i;
    logic                      rom_en_o;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_o;
    logic [DATA_WIDTH-1:0]     rom_rdata_i;
    logic                      ram_req_o;
    logic                      ram_we_o;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0]     ram_wdata_o;
    logic [3:0]                ram_be_o;
    logic                      ram_gnt_i;
    logic                      busy_o;
    logic                      done_o;
    modport slave (
        input  start_i, rom_rdata_i, ram_gnt_i,
        output rom_en_o, rom_addr_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o, busy_o, done_o
    );
    modport master (
        output start_i, rom_rdata_i, ram_gnt_i,
        input  rom_en_o, rom_addr_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o, busy_o, done_o
    );
endinterface

// File: rtl/boot_rom_loader.sv
// boot_rom_loader: copies COPY_WORDS words from ROM word 0.. to RAM at RAM_BASE, one word per RD/CAP/WR pass.
// Ports: clk, rst (async active-high); bus (boot_rom_loader_if.slave): start, ROM read port, RAM write port, busy/done.
// Optional: define BOOT_LOADER_CHECKSUM_EN to add checksum_o, the mod-2^32 sum of words granted this run.
module boot_rom_loader #(
    parameter int ROM_ADDR_WIDTH = 12,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int COPY_WORDS     = 1024,
    parameter int RAM_BASE       = 0
) (
    input logic              clk,
    input logic              rst,
    boot_rom_loader_if.slave bus
`ifdef BOOT_LOADER_CHECKSUM_EN
    , output logic [31:0]    checksum_o
`endif
);
    localparam int IW = $clog2(COPY_WORDS) + 1;
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rd, wr, go, grant, last;
    assign rd    = state_q == RD;
    assign wr    = state_q == WR;
    assign go    = (state_q == IDLE || state_q == DONE) && bus.start_i;
    assign grant = wr && bus.ram_gnt_i;
    assign last  = idx_q == IW'(COPY_WORDS - 1);
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE, DONE: if (go) begin
                state_d = RD;
                idx_d   = '0;
            end
            RD:  state_d = CAP;
            CAP: begin
                data_d  = bus.rom_rdata_i;
                state_d = WR;
            end
            WR: if (bus.ram_gnt_i) begin
                state_d = last ? DONE : RD;
                idx_d   = last ? idx_q : idx_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    assign sum_d = go ? 32'd0 : grant ? sum_q + 32'(data_q) : sum_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end
    assign checksum_o = sum_q;
`endif
    // Address/data outputs are forced to 0 when idle so every output reads 0 under reset.
    assign bus.rom_en_o    = rd;
    assign bus.rom_addr_o  = rd ? ROM_ADDR_WIDTH'({idx_q, 2'b00}) : '0;
    assign bus.ram_req_o   = wr;
    assign bus.ram_we_o    = wr;
    assign bus.ram_be_o    = wr ? 4'hF : 4'h0;
    assign bus.ram_addr_o  = wr ? RAM_ADDR_WIDTH'(RAM_BASE) + RAM_ADDR_WIDTH'({idx_q, 2'b00}) : '0;
    assign bus.ram_wdata_o = wr ? data_q : '0;
    assign bus.busy_o      = rd || state_q == CAP || wr;
    assign bus.done_o      = state_q == DONE;
endmodule

// File: tb/tb_boot_rom_loader.sv
// tb_boot_rom_loader: randomized self-checking bench for boot_rom_loader against a word-list reference model.
module tb_boot_rom_loader;
    logic clk, rst;
    logic [31:0] csum, csum1, csum3;
    logic [31:0] rom_mem [0:15];
    logic [47:0] wq[$], q1[$], q3[$];
    logic [11:0] rq[$];
    int ncmp = 0, nerr = 0;
    int gmode = 0, stall_n = 0, stab_err = 0;
    bit prev_stall = 0;
    logic [15:0] p_addr;
    logic [31:0] p_data;
    boot_rom_loader_if m_if();
    boot_rom_loader_if e1_if();
    boot_rom_loader_if e3_if();
    boot_rom_loader #(.COPY_WORDS(4)) u_dut (
        .clk(clk), .rst(rst), .bus(m_if)
`ifdef BOOT_LOADER_CHECKSUM_EN
        , .checksum_o(csum)
`endif
    );
    boot_rom_loader #(.COPY_WORDS(1), .RAM_BASE(16'hFFFC)) u_e1 (
        .clk(clk), .rst(rst), .bus(e1_if)
`ifdef BOOT_LOADER_CHECKSUM_EN
        , .checksum_o(csum1)
`endif
    );
    boot_rom_loader #(.COPY_WORDS(3), .RAM_BASE(16'hFFF8)) u_e3 (
        .clk(clk), .rst(rst), .bus(e3_if)
`ifdef BOOT_LOADER_CHECKSUM_EN
        , .checksum_o(csum3)
`endif
    );
    initial clk = 0;
    always #5 clk = ~clk;
    // ROM model: data valid the cycle after the enable, garbage otherwise.
    always @(posedge clk) begin
        m_if.rom_rdata_i  <= m_if.rom_en_o ? rom_mem[m_if.rom_addr_o[5:2]] : $urandom();
        e1_if.rom_rdata_i <= e1_if.rom_en_o ? rom_mem[e1_if.rom_addr_o[5:2]] : $urandom();
        e3_if.rom_rdata_i <= e3_if.rom_en_o ? rom_mem[e3_if.rom_addr_o[5:2]] : $urandom();
    end
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && (!m_if.ram_req_o || !m_if.ram_we_o || m_if.ram_be_o != 4'hF ||
                m_if.ram_addr_o != p_addr || m_if.ram_wdata_o != p_data || m_if.rom_en_o)) stab_err++;
            if (m_if.ram_req_o && m_if.rom_en_o) stab_err++;
            if (gmode == 0) m_if.ram_gnt_i = 1;
            else if (gmode == 1) m_if.ram_gnt_i = 1'($urandom_range(0, 1));
            else begin
                m_if.ram_gnt_i = !(m_if.ram_req_o && m_if.ram_addr_o == 16'd4 && stall_n < 5);
                if (m_if.ram_req_o && !m_if.ram_gnt_i) stall_n++;
            end
            if (m_if.rom_en_o) rq.push_back(m_if.rom_addr_o);
            if (m_if.ram_req_o && m_if.ram_gnt_i) wq.push_back({m_if.ram_addr_o, m_if.ram_wdata_o});
            if (e1_if.ram_req_o) q1.push_back({e1_if.ram_addr_o, e1_if.ram_wdata_o});
            if (e3_if.ram_req_o) q3.push_back({e3_if.ram_addr_o, e3_if.ram_wdata_o});
            prev_stall = m_if.ram_req_o && !m_if.ram_gnt_i;
            p_addr = m_if.ram_addr_o;
            p_data = m_if.ram_wdata_o;
        end else prev_stall = 0;
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(m_if.busy_o), 0);
        check({tag, "_done"}, 64'(m_if.done_o), 0);
        check({tag, "_req"}, 64'({m_if.ram_req_o, m_if.ram_we_o, m_if.rom_en_o}), 0);
        check({tag, "_be"}, 64'(m_if.ram_be_o), 0);
        check({tag, "_addr"}, 64'({m_if.rom_addr_o, m_if.ram_addr_o}), 0);
        check({tag, "_wdata"}, 64'(m_if.ram_wdata_o), 0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        check({tag, "_csum"}, 64'(csum), 0);
`endif
    endtask
    task automatic run_main(input int gm, input bit mid, input string tag);
        int n;
        logic [31:0] s = 0;
        wq.delete(); rq.delete(); stab_err = 0; stall_n = 0; gmode = gm;
        @(negedge clk) m_if.start_i = 1;
        @(negedge clk) m_if.start_i = 0;
        check({tag, "_busy"}, 64'(m_if.busy_o), 1);
        check({tag, "_doneclr"}, 64'(m_if.done_o), 0);
        n = 0;
        while (!m_if.done_o && n < 200) begin
            m_if.start_i = mid && n == 4;
            @(negedge clk);
            n++;
        end
        m_if.start_i = 0;
        check({tag, "_done"}, 64'(m_if.done_o), 1);
        if (gm == 0) check({tag, "_cycles"}, 64'(n), 12);
        if (gm == 2) check({tag, "_cycles"}, 64'(n), 17);
        if (gm == 2) check({tag, "_stalls"}, 64'(stall_n), 5);
        repeat (3) @(negedge clk);
        check({tag, "_held"}, 64'({m_if.done_o, m_if.busy_o}), 64'b10);
        check({tag, "_nwr"}, 64'(wq.size()), 4);
        check({tag, "_nrd"}, 64'(rq.size()), 4);
        for (int k = 0; k < 4; k++) begin
            s += rom_mem[k];
            check({tag, "_wr"}, k < wq.size() ? 64'(wq[k]) : 'x, 64'({16'(4 * k), rom_mem[k]}));
            check({tag, "_rd"}, k < rq.size() ? 64'(rq[k]) : 'x, 64'(4 * k));
        end
        check({tag, "_stable"}, 64'(stab_err), 0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        check({tag, "_csum"}, 64'(csum), 64'(s));
`else
        s = 0;
`endif
    endtask
    initial begin
        int n, act;
        rst = 1;
        m_if.start_i = 0; e1_if.start_i = 0; e3_if.start_i = 0;
        m_if.ram_gnt_i = 0; e1_if.ram_gnt_i = 1; e3_if.ram_gnt_i = 1;
        for (int k = 0; k < 16; k++) rom_mem[k] = 32'hA000_0000 + k;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 0;
        run_main(0, 0, "basic");
`ifdef BOOT_LOADER_CHECKSUM_EN
        check("basic_csum_const", 64'(csum), 64'h8000_0006);
`endif
        run_main(2, 0, "stall");
        run_main(0, 1, "midstart");
        run_main(0, 0, "repeat");
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) rom_mem[k] = $urandom();
            run_main(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end
        gmode = 0;
        @(negedge clk) m_if.start_i = 1;
        @(negedge clk) m_if.start_i = 0;
        n = 0;
        while (!(m_if.ram_req_o && m_if.ram_addr_o == 16'd8) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_wr2", 64'(n < 50), 1);
        #1 rst = 1;
        #1 check_zero("rst_mid");
        @(negedge clk);
        @(negedge clk) rst = 0;
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_if.busy_o || m_if.done_o || m_if.rom_en_o || m_if.ram_req_o) act++;
        end
        check("rst_no_resume", 64'(act), 0);
        run_main(0, 0, "after_rst");
        q1.delete(); q3.delete();
        @(negedge clk) begin e1_if.start_i = 1; e3_if.start_i = 1; end
        @(negedge clk) begin e1_if.start_i = 0; e3_if.start_i = 0; end
        repeat (15) @(negedge clk);
        check("e1_done", 64'({e1_if.done_o, e3_if.done_o}), 64'b11);
        check("e1_nwr", 64'(q1.size()), 1);
        check("e1_wr", q1.size() > 0 ? 64'(q1[0]) : 'x, 64'({16'hFFFC, rom_mem[0]}));
        check("e3_nwr", 64'(q3.size()), 3);
        for (int k = 0; k < 3; k++)
            check("e3_wr", k < q3.size() ? 64'(q3[k]) : 'x, 64'({16'(16'hFFF8 + 4 * k), rom_mem[k]}));
`ifdef BOOT_LOADER_CHECKSUM_EN
        check("e1_csum", 64'(csum1), 64'(rom_mem[0]));
        check("e3_csum", 64'(csum3), 64'(32'(rom_mem[0] + rom_mem[1] + rom_mem[2])));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/boot_rom_loader.md
BOOT_ROM_LOADER -- requirements
Module: boot_rom_loader

Interface
REQ-001 The module SHALL have parameter ROM_ADDR_WIDTH, default 12, giving the ROM byte-address width.
REQ-002 The module SHALL have parameter RAM_ADDR_WIDTH, default 16, giving the RAM byte-address width.
REQ-003 The module SHALL have parameter DATA_WIDTH, default 32, giving the word width (fixed 32; other values unsupported).
REQ-004 The module SHALL have parameter COPY_WORDS, default 1024, giving the number of words copied per run (1 .. 2^(ROM_ADDR_WIDTH-2)).
REQ-005 The module SHALL have parameter RAM_BASE, default 0, giving the RAM byte address of word 0 (word-aligned).
REQ-006 The module SHALL have one clock and an asynchronous, active-high reset: clk input 1 (clock), rst input 1 (async reset, active-high).
REQ-007 start_i  input  1  one-cycle pulse that starts a copy run.
REQ-008 rom_en_o  output  1  ROM read enable.
REQ-009 rom_addr_o  output  ROM_ADDR_WIDTH  ROM byte address, bits [1:0] always 0.
REQ-010 rom_rdata_i  input  DATA_WIDTH  ROM read data, valid the cycle after rom_en_o.
REQ-011 ram_req_o, ram_we_o  output  1 each  RAM request and write enable.
REQ-012 ram_addr_o  output  RAM_ADDR_WIDTH  RAM byte address.
REQ-013 ram_wdata_o  output  DATA_WIDTH; ram_be_o  output  4  write data and byte enables.
REQ-014 ram_gnt_i  input  1  RAM grant; a write completes in a cycle where ram_req_o and ram_gnt_i are both 1.
REQ-015 busy_o, done_o  output  1 each  copy run in progress; run finished (sticky).

Function
REQ-016 The FSM SHALL have the states IDLE, RD, CAP, WR and DONE, with a word counter idx of width clog2(COPY_WORDS)+1.
REQ-017 In IDLE or DONE, start_i=1 SHALL clear idx and done_o and move the FSM to RD.
REQ-018 In RD, the module SHALL drive rom_en_o=1 and rom_addr_o=4*idx for exactly one cycle, then move to CAP.
REQ-019 In CAP, the module SHALL register rom_rdata_i into the write-data register and move to WR.
REQ-020 In WR, the module SHALL drive ram_req_o=1, ram_we_o=1, ram_be_o=4'hF, ram_addr_o=RAM_BASE+4*idx, and ram_wdata_o from the register.
REQ-021 In WR, all RAM outputs SHALL hold stable while ram_gnt_i=0, with no ROM access and no timeout.
REQ-022 On grant in WR with idx=COPY_WORDS-1, the FSM SHALL go to DONE; otherwise it SHALL increment idx and go to RD.
REQ-023 With immediate grant, each word SHALL take 3 cycles, so a full run takes 3*COPY_WORDS cycles from the first RD.
REQ-024 busy_o SHALL be 1 exactly in RD, CAP and WR.
REQ-025 done_o SHALL be 1 in DONE and hold until the next start_i.
REQ-026 start_i SHALL be ignored in RD, CAP and WR.
REQ-027 ram_req_o, ram_we_o and rom_en_o SHALL be 0 outside WR and RD respectively.
REQ-028 ram_be_o SHALL be 0 outside WR; rom_addr_o and ram_addr_o are don't-care when their enables are 0.
REQ-029 RAM address arithmetic SHALL wrap modulo 2^RAM_ADDR_WIDTH.
REQ-030 COPY_WORDS=1 SHALL give the sequence RD, CAP, WR, DONE.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, idx=0, and every output and register to 0, including during a run.
REQ-032 A partially copied run SHALL not resume after reset; a new start_i is required.

Configuration
REQ-033 With macro BOOT_LOADER_CHECKSUM_EN defined, the module SHALL add output checksum_o (32 bits) equal to the mod-2^32 sum of all words granted in the current run.
REQ-034 With BOOT_LOADER_CHECKSUM_EN defined, checksum_o SHALL be cleared on start_i, updated on each grant, valid and held while done_o=1, and reset to 0.
REQ-035 Without BOOT_LOADER_CHECKSUM_EN, the checksum_o port and its adder SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 COPY_WORDS=4, ROM word k=0xA0000000+k, ram_gnt_i tied 1, start pulse -> RAM writes at 0,4,8,12 with 0xA0000000..0xA0000003; done_o rises 12 cycles after the first RD; checksum_o=0x8000_0006.
REQ-037 ram_gnt_i held 0 for 5 cycles on word 1 -> ram_addr_o=4 and ram_wdata_o held stable; rom_en_o stays 0; exactly one write per word.
REQ-038 start_i pulsed during busy -> ignored, and the run completes exactly once; start_i pulsed in DONE -> done_o clears and the run repeats from address 0.
REQ-039 rst asserted in WR of word 2 -> all outputs 0 in the same cycle, FSM in IDLE; after release, no activity until start_i.
REQ-040 COPY_WORDS=1, RAM_BASE=0xFFFC, RAM_ADDR_WIDTH=16 -> a single write to 0xFFFC, then DONE; repeat with RAM_BASE=0xFFF8 and COPY_WORDS=3 -> writes to 0xFFF8, 0xFFFC, 0x0000 (wrap).
